jpeg_quant_zz: RTL and testbench

JPEG_QUANT_ZZ -- requirements
Module: jpeg_quant_zz

---
 rtl/jpeg_quant_zz_pkg.sv | 25 ++
 rtl/jpeg_quant_mul.sv | 40 ++++
 rtl/jpeg_quant_zz.sv | 132 +++++++++++++
 tb/tb_jpeg_quant_zz.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_quant_zz_pkg.sv
// jpeg_quant_zz_pkg : shared widths, defaults and FSM encoding for the quantiser/zigzag block.
// Revision: 1.0
`default_nettype none

package jpeg_quant_zz_pkg;

  localparam int DU_SIZE_DFLT = 64;
  localparam int QSHIFT_DFLT  = 11;
  localparam int DCT_W        = 18;
  localparam int ZZ_W         = 15;
  localparam int FD_W         = 8;
  localparam int IDX_W        = 6;
  localparam int PROD_W       = DCT_W + FD_W + 1;
  localparam int DRAIN_CYC    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/jpeg_quant_mul.sv
// jpeg_quant_mul : registered signed coefficient x unsigned reciprocal, round half up, shift.
// Revision: 1.0
`default_nettype none

module jpeg_quant_mul
  import jpeg_quant_zz_pkg::*;
#(
  parameter int QSHIFT = QSHIFT_DFLT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [DCT_W-1:0] dct,
  input  logic        [FD_W-1:0]  fd,
  output logic signed [ZZ_W-1:0]  q
);

  localparam int RND = 1 << (QSHIFT - 1);

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rounded;
  logic signed [ZZ_W-1:0]   q_d;
  logic signed [ZZ_W-1:0]   q_q;

  always_comb begin
    prod    = PROD_W'(dct) * PROD_W'($signed({1'b0, fd}));
    rounded = prod + PROD_W'(RND);
    // Result magnitude never exceeds 16320, so dropping the upper bits is lossless.
    q_d     = ZZ_W'(rounded >>> QSHIFT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/jpeg_quant_zz.sv
// jpeg_quant_zz : quantises one 64-coefficient DU and writes it back in zigzag order.
// Revision: 1.0
`default_nettype none

module jpeg_quant_zz
  import jpeg_quant_zz_pkg::*;
#(
  parameter int DU_SIZE = DU_SIZE_DFLT,
  parameter int QSHIFT  = QSHIFT_DFLT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    comp_sel,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        dctdu_ram_ar,
  input  logic signed [DCT_W-1:0] dctdu_ram_do,
  output logic [IDX_W:0]          fdtbl_rom_a,
  input  logic [FD_W-1:0]         fdtbl_rom_d,
  output logic [IDX_W-1:0]        zzidx_rom_a,
  input  logic [IDX_W-1:0]        zzidx_rom_d,
  output logic [IDX_W-1:0]        zzdu_ram_aw,
  output logic signed [ZZ_W-1:0]  zzdu_ram_di,
  output logic                    zzdu_ram_we
);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              drain_q, drain_d;
  logic                    sel_q, sel_d;
  logic                    rd_v_q, rd_v_d;
  logic                    s1_v_q, s1_v_d;
  logic                    s2_v_q, s2_v_d;
  logic signed [DCT_W-1:0] dct_q, dct_d;
  logic [FD_W-1:0]         fd_q, fd_d;
  logic [IDX_W-1:0]        zz1_q, zz1_d;
  logic [IDX_W-1:0]        zz2_q, zz2_d;
  logic signed [ZZ_W-1:0]  mul_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          sel_d   = comp_sel;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (idx_q == IDX_W'(DU_SIZE - 1)) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(DRAIN_CYC - 1)) state_d = ST_DONE;
        else                              drain_d = drain_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM/ROM data for address i arrives one cycle later; rd_v marks that cycle.
  always_comb begin
    rd_v_d = (state_q == ST_RUN);
    s1_v_d = rd_v_q;
    s2_v_d = s1_v_q;
    dct_d  = rd_v_q ? dctdu_ram_do : dct_q;
    fd_d   = rd_v_q ? fdtbl_rom_d  : fd_q;
    zz1_d  = rd_v_q ? zzidx_rom_d  : zz1_q;
    zz2_d  = zz1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      sel_q   <= 1'b0;
      rd_v_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      dct_q   <= '0;
      fd_q    <= '0;
      zz1_q   <= '0;
      zz2_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      sel_q   <= sel_d;
      rd_v_q  <= rd_v_d;
      s1_v_q  <= s1_v_d;
      s2_v_q  <= s2_v_d;
      dct_q   <= dct_d;
      fd_q    <= fd_d;
      zz1_q   <= zz1_d;
      zz2_q   <= zz2_d;
    end
  end

  jpeg_quant_mul #(
    .QSHIFT (QSHIFT)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .dct     (dct_q),
    .fd      (fd_q),
    .q       (mul_q)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign dctdu_ram_ar = idx_q;
  assign zzidx_rom_a  = idx_q;
  assign fdtbl_rom_a  = {sel_q, idx_q};
  assign zzdu_ram_we  = s2_v_q;
  assign zzdu_ram_aw  = zz2_q;
  assign zzdu_ram_di  = mul_q;

endmodule

`default_nettype wire

// File: tb/tb_jpeg_quant_zz.sv
// tb_jpeg_quant_zz : scoreboard bench for jpeg_quant_zz with behavioural RAM/ROM models.
// Revision: 1.0
`default_nettype none

module tb_jpeg_quant_zz;

  localparam int QSHIFT = 11;

  typedef struct {
    longint addr;
    longint data;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               comp_sel;
  logic               busy;
  logic               done;
  logic [5:0]         dctdu_ram_ar;
  logic signed [17:0] dctdu_ram_do;
  logic [6:0]         fdtbl_rom_a;
  logic [7:0]         fdtbl_rom_d;
  logic [5:0]         zzidx_rom_a;
  logic [5:0]         zzidx_rom_d;
  logic [5:0]         zzdu_ram_aw;
  logic signed [14:0] zzdu_ram_di;
  logic               zzdu_ram_we;

  logic signed [17:0] dct_mem [0:63];
  logic [7:0]         fd_mem  [0:127];
  logic [5:0]         zz_tab  [0:63];
  logic signed [14:0] out_mem [0:63];

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          writes = 0;
  logic [63:0] written = '0;

  jpeg_quant_zz dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .comp_sel     (comp_sel),
    .busy         (busy),
    .done         (done),
    .dctdu_ram_ar (dctdu_ram_ar),
    .dctdu_ram_do (dctdu_ram_do),
    .fdtbl_rom_a  (fdtbl_rom_a),
    .fdtbl_rom_d  (fdtbl_rom_d),
    .zzidx_rom_a  (zzidx_rom_a),
    .zzidx_rom_d  (zzidx_rom_d),
    .zzdu_ram_aw  (zzdu_ram_aw),
    .zzdu_ram_di  (zzdu_ram_di),
    .zzdu_ram_we  (zzdu_ram_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dctdu_ram_do <= dct_mem[dctdu_ram_ar];
    fdtbl_rom_d  <= fd_mem[fdtbl_rom_a];
    zzidx_rom_d  <= zz_tab[zzidx_rom_a];
    if (zzdu_ram_we) out_mem[zzdu_ram_aw] <= zzdu_ram_di;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Write monitor: each write must match the next expected entry in natural order.
  always @(negedge clk) begin
    if (reset_n && zzdu_ram_we) begin
      exp_t e;
      if (!busy) chk("we_while_idle", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", longint'(zzdu_ram_aw), e.addr);
        chk("wr_data", longint'(zzdu_ram_di), e.data);
      end
      if (written[zzdu_ram_aw]) chk("dup_addr", 1, 0);
      written[zzdu_ram_aw] = 1'b1;
      writes++;
    end
  end

  task automatic load_exp(input bit sel);
    exp_t   e;
    longint p;
    exp_q.delete();
    writes  = 0;
    written = '0;
    for (int i = 0; i < 64; i++) begin
      p      = longint'(dct_mem[i]) * longint'({1'b0, fd_mem[{sel, 6'(i)}]});
      e.addr = longint'(zz_tab[i]);
      e.data = (p + (longint'(1) << (QSHIFT - 1))) >>> QSHIFT;
      exp_q.push_back(e);
    end
  endtask

  task automatic post_checks();
    chk("wr_count", writes, 64);
    chk("q_empty", exp_q.size(), 0);
    chk("all_addr", longint'(written == '1), 1);
  endtask

  // pre: start already high with comp_sel valid in the cycle just sampled.
  task automatic run_du(input bit sel, input bit extra, input bit probe, input bit pre);
    int lat;
    lat = -1;
    if (!pre) begin
      load_exp(sel);
      @(negedge clk);
      start    = 1'b1;
      comp_sel = sel;
    end
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      start    = extra && (k == 10 || k == 40);
      comp_sel = ~sel;
      if (k == 1) chk("busy_run", busy, 1);
      if (k <= 64) begin
        chk("dct_ar", dctdu_ram_ar, k - 1);
        chk("zzidx_a", zzidx_rom_a, k - 1);
        chk("fdtbl_a", fdtbl_rom_a, (sel ? 64 : 0) + k - 1);
      end
      if (done) lat = k;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    else         chk("done_latency", lat, 68);
    post_checks();
    if (probe) begin
      load_exp(sel);
      start    = 1'b1;
      comp_sel = sel;
      @(negedge clk);
      chk("start_in_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_idle", busy, 0);
    end
  endtask

  task automatic abort_run();
    int w_at_rst;
    int dcnt;
    load_exp(0);
    @(negedge clk);
    start    = 1'b1;
    comp_sel = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    w_at_rst = writes;
    chk("abort_we", zzdu_ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ar", dctdu_ram_ar, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_no_write", writes, w_at_rst);
    chk("abort_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    comp_sel = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dct_mem[i]     = '0;
      fd_mem[i]      = 8'((i * 3 + 1) & 255);
      fd_mem[64 + i] = 8'(255 - i);
      zz_tab[i]      = 6'((i * 37 + 5) % 64);
      out_mem[i]     = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", zzdu_ram_we, 0);
    chk("rst_ar", dctdu_ram_ar, 0);
    chk("rst_fdtbl_a", fdtbl_rom_a, 0);
    chk("rst_zzidx_a", zzidx_rom_a, 0);
    chk("rst_aw", zzdu_ram_aw, 0);
    chk("rst_di", zzdu_ram_di, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_du(0, 0, 0, 0);

    for (int i = 0; i < 64; i++) dct_mem[i] = 18'($urandom_range(0, 4000)) - 18'sd2000;
    dct_mem[0] = 18'sd1000;
    fd_mem[0]  = 8'd64;
    run_du(0, 0, 0, 0);
    chk("q_pos_1000", out_mem[zz_tab[0]], 31);
    dct_mem[0] = -18'sd1000;
    run_du(0, 0, 0, 0);
    chk("q_neg_1000", out_mem[zz_tab[0]], -31);

    for (int i = 0; i < 64; i++) begin
      dct_mem[i] = 18'sd131071;
      fd_mem[i]  = 8'd255;
    end
    run_du(0, 0, 0, 0);
    chk("q_max", out_mem[zz_tab[7]], 16320);
    for (int i = 0; i < 64; i++) dct_mem[i] = -18'sd131072;
    run_du(0, 0, 0, 0);
    chk("q_min", out_mem[zz_tab[7]], -16320);

    for (int i = 0; i < 64; i++) begin
      dct_mem[i] = 18'($urandom());
      fd_mem[i]  = 8'((i * 3 + 1) & 255);
    end
    run_du(1, 0, 0, 0);
    run_du(0, 1, 0, 0);
    run_du(1, 0, 1, 0);
    run_du(1, 0, 0, 1);

    abort_run();
    run_du(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
